// File: rtl/vmu_pkg.sv
// -----------------------------------------------------------------------------
// vmu_pkg
// Shared definitions for the vector memory unit:
//   - default LANES / DATA_WIDTH / ADDRESS_WIDTH values
//   - FSM state enumeration
// -----------------------------------------------------------------------------
package vmu_pkg;

    localparam int VMU_LANES         = 4;
    localparam int VMU_DATA_WIDTH    = 32;
    localparam int VMU_ADDRESS_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        DONE  = 2'd3
    } vmu_state_e;

endpackage

// File: rtl/vmu_addr_gen.sv
// -----------------------------------------------------------------------------
// vmu_addr_gen
// Lane counter and lane address generator for the vector memory unit.
// The address of lane i is base + i*step, wrapping modulo 2^ADDRESS_WIDTH.
//
// Ports:
//   clk      in   clock
//   reset    in   synchronous active-high reset (counter -> 0)
//   clear    in   restart the lane counter at 0 (new request accepted)
//   advance  in   step to the next lane at this edge
//   base     in   ADDRESS_WIDTH  word address of lane 0
//   step     in   ADDRESS_WIDTH  address distance between adjacent lanes
//   lane     out  INDEX_WIDTH    current lane index
//   address  out  ADDRESS_WIDTH  address of the current lane
//   last     out  current lane is lane LANES-1
// -----------------------------------------------------------------------------
module vmu_addr_gen
    import vmu_pkg::*;
#(
    parameter int LANES         = VMU_LANES,
    parameter int ADDRESS_WIDTH = VMU_ADDRESS_WIDTH,
    parameter int INDEX_WIDTH   = $clog2(LANES)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     advance,
    input  logic [ADDRESS_WIDTH-1:0] base,
    input  logic [ADDRESS_WIDTH-1:0] step,
    output logic [INDEX_WIDTH-1:0]   lane,
    output logic [ADDRESS_WIDTH-1:0] address,
    output logic                     last
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values of its neighbours, as real hardware does.
    always_ff @(posedge clk) begin
        if (reset) begin
            lane <= '0;
        end else if (clear) begin
            lane <= '0;
        end else if (advance) begin
            // LANES is a power of two, so the counter wraps back to 0 by itself
            lane <= lane + INDEX_WIDTH'(1);
        end
    end

    // Product and sum are both truncated to ADDRESS_WIDTH, giving the
    // modulo-2^ADDRESS_WIDTH wrap of the address space.
    assign address = base + step * ADDRESS_WIDTH'(lane);
    assign last    = (lane == INDEX_WIDTH'(LANES - 1));

endmodule

// File: rtl/vector_mem_unit.sv
// -----------------------------------------------------------------------------
// vector_mem_unit
// Gathers (load) or scatters (store) a LANES-wide vector to/from a
// word-addressed memory, one lane per clock.
//
// Optional feature macro: VMU_STRIDED_EN
//   defined   -> a 'stride' port exists and is captured with start;
//                lane i address = baseAddress + i*stride
//   undefined -> no stride port; lane i address = baseAddress + i
//
// Ports:
//   clk              in   clock
//   reset            in   synchronous active-high reset
//   start            in   request strobe, honoured only in IDLE
//   isStore          in   1 = store, 0 = load (captured with start)
//   baseAddress      in   ADDRESS_WIDTH  word address of lane 0
//   storeData        in   LANES*DATA_WIDTH  store vector, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   busy             out  high in every state except IDLE
//   done             out  one-cycle completion pulse
//   loadData         out  LANES*DATA_WIDTH  gathered load vector
//   memReadAddress   out  ADDRESS_WIDTH  read address (memory answers combinationally)
//   memOutputData    in   DATA_WIDTH     read data for memReadAddress
//   memWriteAddress  out  ADDRESS_WIDTH  write address
//   memInputData     out  DATA_WIDTH     write data
//   memWriteEnable   out  write strobe, committed by the memory at posedge clk
//   stride           in   ADDRESS_WIDTH  lane address step (VMU_STRIDED_EN only)
// -----------------------------------------------------------------------------
module vector_mem_unit
    import vmu_pkg::*;
#(
    parameter int LANES         = VMU_LANES,
    parameter int DATA_WIDTH    = VMU_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = VMU_ADDRESS_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          isStore,
    input  logic [ADDRESS_WIDTH-1:0]      baseAddress,
    input  logic [LANES*DATA_WIDTH-1:0]   storeData,
    output logic                          busy,
    output logic                          done,
    output logic [LANES*DATA_WIDTH-1:0]   loadData,
    output logic [ADDRESS_WIDTH-1:0]      memReadAddress,
    input  logic [DATA_WIDTH-1:0]         memOutputData,
    output logic [ADDRESS_WIDTH-1:0]      memWriteAddress,
    output logic [DATA_WIDTH-1:0]         memInputData,
    output logic                          memWriteEnable
`ifdef VMU_STRIDED_EN
    ,
    input  logic [ADDRESS_WIDTH-1:0]      stride
`endif
);

    localparam int INDEX_WIDTH = $clog2(LANES);

    vmu_state_e state;
    vmu_state_e next_state;

    logic [ADDRESS_WIDTH-1:0]    base_q;
    logic [ADDRESS_WIDTH-1:0]    step;
    logic [LANES*DATA_WIDTH-1:0] store_q;
    logic [LANES*DATA_WIDTH-1:0] load_q;

    logic [INDEX_WIDTH-1:0]      lane;
    logic [ADDRESS_WIDTH-1:0]    lane_address;
    logic                        last_lane;

    logic                        accept;
    logic                        advance;

    assign accept  = (state == IDLE) && start;
    assign advance = (state == LOAD) || (state == STORE);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // Request capture
    // -------------------------------------------------------------------------
    // NOTE: the captured request fields have no reset; they are always written
    // by an accepted start before any state that reads them, so resetting them
    // would only add fan-out on the reset net.
    always_ff @(posedge clk) begin
        if (accept) begin
            base_q  <= baseAddress;
            store_q <= storeData;
        end
    end

`ifdef VMU_STRIDED_EN
    logic [ADDRESS_WIDTH-1:0] stride_q;

    always_ff @(posedge clk) begin
        if (accept) begin
            stride_q <= stride;
        end
    end

    assign step = stride_q;
`else
    assign step = ADDRESS_WIDTH'(1);
`endif

    // -------------------------------------------------------------------------
    // Lane counter / address generator
    // -------------------------------------------------------------------------
    vmu_addr_gen #(
        .LANES         (LANES),
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .INDEX_WIDTH   (INDEX_WIDTH)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept),
        .advance (advance),
        .base    (base_q),
        .step    (step),
        .lane    (lane),
        .address (lane_address),
        .last    (last_lane)
    );

    // -------------------------------------------------------------------------
    // Load gather register: one lane filled per LOAD cycle; held otherwise,
    // so stores and idle time leave the last loaded vector visible.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            load_q <= '0;
        end else if (state == LOAD) begin
            load_q[lane*DATA_WIDTH +: DATA_WIDTH] <= memOutputData;
        end
    end

    assign loadData = load_q;

    // -------------------------------------------------------------------------
    // Next state and outputs
    // -------------------------------------------------------------------------
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state      = state;
        busy            = 1'b1;
        done            = 1'b0;
        memReadAddress  = '0;
        memWriteAddress = '0;
        memInputData    = '0;
        memWriteEnable  = 1'b0;

        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    next_state = isStore ? STORE : LOAD;
                end
            end

            LOAD: begin
                memReadAddress = lane_address;
                if (last_lane) begin
                    next_state = DONE;
                end
            end

            STORE: begin
                // Suppressed while reset is high so an abandoned store never
                // commits a word at the reset edge.
                memWriteEnable  = ~reset;
                memWriteAddress = lane_address;
                memInputData    = store_q[lane*DATA_WIDTH +: DATA_WIDTH];
                if (last_lane) begin
                    next_state = DONE;
                end
            end

            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vector_mem_unit.sv
// -----------------------------------------------------------------------------
// tb_vector_mem_unit
// Self-checking bench for vector_mem_unit (default parameters). A 64-word
// memory model (low 6 address bits) is attached to the DUT; a separate
// reference image of that memory plus the expected loadData vector are
// updated from the behavioural rules (lane i at base + i*step, stores in lane
// order, loads gather lanes, loadData held across stores).
// Define VMU_STRIDED_EN for both RTL and bench to exercise the stride port.
// -----------------------------------------------------------------------------
module tb_vector_mem_unit;

    localparam int LANES     = 4;
    localparam int DW        = 32;
    localparam int AW        = 32;
    localparam int MEM_WORDS = 64;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 isStore;
    logic [AW-1:0]        baseAddress;
    logic [LANES*DW-1:0]  storeData;
    logic                 busy;
    logic                 done;
    logic [LANES*DW-1:0]  loadData;
    logic [AW-1:0]        memReadAddress;
    logic [DW-1:0]        memOutputData;
    logic [AW-1:0]        memWriteAddress;
    logic [DW-1:0]        memInputData;
    logic                 memWriteEnable;
`ifdef VMU_STRIDED_EN
    logic [AW-1:0]        stride;
`endif

    // memory seen by the DUT, the image used to preload it, and the reference
    logic [DW-1:0] mem       [MEM_WORDS];
    logic [DW-1:0] pre_image [MEM_WORDS];
    logic          pre_load;
    logic [DW-1:0] ref_mem   [MEM_WORDS];
    logic [LANES*DW-1:0] ref_load;

    int tests = 0;
    int fails = 0;

    // per-operation observations
    logic [AW-1:0] obs_addr[$];
    logic [DW-1:0] obs_wdata[$];
    int            done_at;
    int            done_count;
    int            busy_mask;

    always #5 clk = ~clk;

    assign memOutputData = mem[memReadAddress[5:0]];

    always @(posedge clk) begin
        if (pre_load) begin
            mem <= pre_image;
        end else if (memWriteEnable) begin
            mem[memWriteAddress[5:0]] <= memInputData;
        end
    end

    vector_mem_unit #(
        .LANES         (LANES),
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .isStore         (isStore),
        .baseAddress     (baseAddress),
        .storeData       (storeData),
        .busy            (busy),
        .done            (done),
        .loadData        (loadData),
        .memReadAddress  (memReadAddress),
        .memOutputData   (memOutputData),
        .memWriteAddress (memWriteAddress),
        .memInputData    (memInputData),
        .memWriteEnable  (memWriteEnable)
`ifdef VMU_STRIDED_EN
        ,
        .stride          (stride)
`endif
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- helpers
    function automatic logic [LANES*DW-1:0] rand_vec();
        logic [LANES*DW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = $urandom;
        return v;
    endfunction

    task automatic commit_mem();
        pre_image = ref_mem;
        @(negedge clk);
        pre_load = 1'b1;
        @(negedge clk);
        pre_load = 1'b0;
    endtask

    task automatic randomize_mem();
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = $urandom;
        commit_mem();
    endtask

    // Issue one request and record every cycle until the unit is idle again.
    // pulse[k] drives start during cycle k after acceptance (k = 0..LANES).
    task automatic run_op(input logic st, input logic [AW-1:0] base,
                          input logic [AW-1:0] stp, input logic [LANES*DW-1:0] sdata,
                          input logic [4:0] pulse);
        obs_addr.delete();
        obs_wdata.delete();
        done_at    = -1;
        done_count = 0;
        busy_mask  = 0;
        @(negedge clk);
        start       = 1'b1;
        isStore     = st;
        baseAddress = base;
        storeData   = sdata;
`ifdef VMU_STRIDED_EN
        stride      = stp;
`endif
        @(negedge clk);
        // scramble request fields: only the captured copies may matter now
        start       = 1'b0;
        isStore     = ~st;
        baseAddress = $urandom;
        storeData   = rand_vec();
`ifdef VMU_STRIDED_EN
        stride      = $urandom;
`endif
        for (int k = 0; k < LANES + 3; k++) begin
            if (busy) busy_mask = busy_mask | (1 << k);
            if (busy && !done) begin
                if (memWriteEnable) begin
                    obs_addr.push_back(memWriteAddress);
                    obs_wdata.push_back(memInputData);
                end else begin
                    obs_addr.push_back(memReadAddress);
                end
            end
            if (done) begin
                done_count++;
                if (done_at < 0) done_at = k;
            end
            start = (k <= LANES) ? pulse[k] : 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // Compare the last run_op against the reference rules and update the model.
    task automatic check_op(input string name, input logic st, input logic [AW-1:0] base,
                            input logic [AW-1:0] stp, input logic [LANES*DW-1:0] sdata);
        logic [AW-1:0] step;
        logic [AW-1:0] a;
        int            bad;
`ifdef VMU_STRIDED_EN
        step = stp;
`else
        step = 1;
`endif
        tests++;
        if (done_at !== LANES) begin
            fails++;
            $display("FAIL %s done_cycle: got %0d expected %0d", name, done_at, LANES);
        end
        tests++;
        if (done_count !== 1) begin
            fails++;
            $display("FAIL %s done_pulses: got %0d expected 1", name, done_count);
        end
        tests++;
        if (busy_mask !== ((1 << (LANES + 1)) - 1)) begin
            fails++;
            $display("FAIL %s busy_cycles: got %b expected %b", name, busy_mask, (1 << (LANES + 1)) - 1);
        end
        tests++;
        if (obs_addr.size() !== LANES || obs_wdata.size() !== (st ? LANES : 0)) begin
            fails++;
            $display("FAIL %s access_count: got %0d/%0d writes expected %0d/%0d",
                     name, obs_addr.size(), obs_wdata.size(), LANES, st ? LANES : 0);
        end else begin
            for (int i = 0; i < LANES; i++) begin
                a = base + step * AW'(i);
                tests++;
                if (obs_addr[i] !== a) begin
                    fails++;
                    $display("FAIL %s lane%0d_addr: got %h expected %h", name, i, obs_addr[i], a);
                end
                if (st) begin
                    tests++;
                    if (obs_wdata[i] !== sdata[i*DW +: DW]) begin
                        fails++;
                        $display("FAIL %s lane%0d_wdata: got %h expected %h",
                                 name, i, obs_wdata[i], sdata[i*DW +: DW]);
                    end
                end
            end
        end
        // reference update
        if (st) begin
            for (int i = 0; i < LANES; i++) begin
                a = base + step * AW'(i);
                ref_mem[a[5:0]] = sdata[i*DW +: DW];
            end
        end else begin
            for (int i = 0; i < LANES; i++) begin
                a = base + step * AW'(i);
                ref_load[i*DW +: DW] = ref_mem[a[5:0]];
            end
        end
        tests++;
        if (loadData !== ref_load) begin
            fails++;
            $display("FAIL %s loadData: got %h expected %h", name, loadData, ref_load);
        end
        bad = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL %s memory_image: got %0d differing words expected 0", name, bad);
        end
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        reset       = 1'b1;
        start       = 1'b1;     // reset must win over start
        isStore     = 1'b1;
        baseAddress = 32'h0000_0010;
        storeData   = rand_vec();
        pre_load    = 1'b0;
`ifdef VMU_STRIDED_EN
        stride      = 32'd3;
`endif
        repeat (3) @(negedge clk);
        tests++;
        if ({busy, done, memWriteEnable} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags: got busy/done/we=%b expected 000", {busy, done, memWriteEnable});
        end
        tests++;
        if (memReadAddress !== '0 || memWriteAddress !== '0 || memInputData !== '0) begin
            fails++;
            $display("FAIL reset_addr: got rd=%h wr=%h wd=%h expected 0",
                     memReadAddress, memWriteAddress, memInputData);
        end
        tests++;
        if (loadData !== '0) begin
            fails++;
            $display("FAIL reset_loadData: got %h expected 0", loadData);
        end
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle_after: got busy=%b expected 0", busy);
        end
        ref_load = '0;
    endtask

    task automatic test_load_basic();
        logic [LANES*DW-1:0] exp;
        randomize_mem();
        ref_mem[8]  = 32'hA;
        ref_mem[9]  = 32'hB;
        ref_mem[10] = 32'hC;
        ref_mem[11] = 32'hD;
        commit_mem();
        run_op(1'b0, 32'd8, 32'd1, rand_vec(), 5'b0);
        check_op("load_basic", 1'b0, 32'd8, 32'd1, '0);
        exp = {32'hD, 32'hC, 32'hB, 32'hA};
        tests++;
        if (loadData !== exp) begin
            fails++;
            $display("FAIL load_basic_values: got %h expected %h", loadData, exp);
        end
    endtask

    task automatic test_store_basic();
        logic [LANES*DW-1:0] sd;
        sd = {32'h44, 32'h33, 32'h22, 32'h11};
        run_op(1'b1, 32'd20, 32'd1, sd, 5'b0);
        check_op("store_basic", 1'b1, 32'd20, 32'd1, sd);
        tests++;
        if (mem[20] !== 32'h11 || mem[21] !== 32'h22 || mem[22] !== 32'h33 || mem[23] !== 32'h44) begin
            fails++;
            $display("FAIL store_basic_words: got %h %h %h %h expected 11 22 33 44",
                     mem[20], mem[21], mem[22], mem[23]);
        end
    endtask

    task automatic test_start_ignored();
        // start pulsed in every busy cycle, including DONE
        run_op(1'b0, 32'd40, 32'd1, rand_vec(), 5'b11111);
        check_op("start_ignored", 1'b0, 32'd40, 32'd1, '0);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL start_ignored_idle: got busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_store();
        logic [LANES*DW-1:0] sd;
        logic [DW-1:0]       old2, old3;
        sd   = rand_vec();
        old2 = ref_mem[32];
        old3 = ref_mem[33];
        @(negedge clk);
        start       = 1'b1;
        isStore     = 1'b1;
        baseAddress = 32'd30;
        storeData   = sd;
`ifdef VMU_STRIDED_EN
        stride      = 32'd1;
`endif
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);          // lane 0 committed at the previous edge... lane 1 next
        @(negedge clk);          // lanes 0 and 1 committed
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if ({busy, done, memWriteEnable} !== 3'b000 || memWriteAddress !== '0 ||
            memReadAddress !== '0 || loadData !== '0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got busy/done/we=%b wr=%h rd=%h ld=%h expected all 0",
                     {busy, done, memWriteEnable}, memWriteAddress, memReadAddress, loadData);
        end
        tests++;
        if (mem[30] !== sd[0 +: DW] || mem[31] !== sd[DW +: DW]) begin
            fails++;
            $display("FAIL mid_reset_written: got %h %h expected %h %h",
                     mem[30], mem[31], sd[0 +: DW], sd[DW +: DW]);
        end
        tests++;
        if (mem[32] !== old2 || mem[33] !== old3) begin
            fails++;
            $display("FAIL mid_reset_untouched: got %h %h expected %h %h", mem[32], mem[33], old2, old3);
        end
        reset = 1'b0;
        ref_mem[30] = sd[0 +: DW];
        ref_mem[31] = sd[DW +: DW];
        ref_load    = '0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        run_op(1'b0, 32'hFFFF_FFFE, 32'd1, rand_vec(), 5'b0);
        tests++;
        if (obs_addr.size() !== 4 || obs_addr[0] !== 32'hFFFF_FFFE || obs_addr[1] !== 32'hFFFF_FFFF ||
            obs_addr[2] !== 32'h0 || obs_addr[3] !== 32'h1) begin
            fails++;
            $display("FAIL wrap_addresses: got %p expected FFFFFFFE FFFFFFFF 0 1", obs_addr);
        end
        check_op("wrap", 1'b0, 32'hFFFF_FFFE, 32'd1, '0);
    endtask

`ifdef VMU_STRIDED_EN
    task automatic test_stride();
        run_op(1'b0, 32'd4, 32'd2, rand_vec(), 5'b0);
        tests++;
        if (obs_addr.size() !== 4 || obs_addr[0] !== 32'd4 || obs_addr[1] !== 32'd6 ||
            obs_addr[2] !== 32'd8 || obs_addr[3] !== 32'd10) begin
            fails++;
            $display("FAIL stride_addresses: got %p expected 4 6 8 10", obs_addr);
        end
        check_op("stride", 1'b0, 32'd4, 32'd2, '0);
    endtask
`endif

    task automatic test_random();
        logic                st;
        logic [AW-1:0]       base, stp;
        logic [LANES*DW-1:0] sd;
        logic [4:0]          pulse;
        for (int n = 0; n < 24; n++) begin
            st    = 1'($urandom_range(0, 1));
            base  = $urandom;
            stp   = (n % 3 == 0) ? $urandom : AW'($urandom_range(0, 9));
            sd    = rand_vec();
            pulse = 5'($urandom);
            run_op(st, base, stp, sd, pulse);
            check_op($sformatf("random%0d", n), st, base, stp, sd);
        end
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_store_basic();
        test_start_ignored();
        test_reset_mid_store();
        test_wrap();
`ifdef VMU_STRIDED_EN
        test_stride();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
